fp_add_arbiter: RTL

FP_ADD_ARBITER -- requirements
Module: fp_add_arbiter

---
 rtl/fp_add_arbiter_pkg.sv | 31 +++
 rtl/fp_add_arbiter_floating_addition.sv | 150 +++++++++++++++
 rtl/fp_add_arbiter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/fp_add_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// fp_add_arbiter_pkg
// Shared definitions for the two-requester floating-point add arbiter:
//   - state_t        : 2-bit FSM state encoding (IDLE / EXEC / RESP)
//   - OP_COUNT_W     : width of the completed-operation counter
//   - FP_XLEN        : operand width the shared adder is built for
//   - EXP_MSB/EXP_LSB: exponent field position inside an FP_XLEN word
//   - EXP_W / MAN_W  : exponent and stored-mantissa widths
//   - EXP_ALL_ONES   : exponent pattern marking Inf/NaN
//   - QNAN           : canonical quiet NaN produced by the adder
// ---------------------------------------------------------------------------
package fp_add_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    localparam int OP_COUNT_W = 16;

    localparam int FP_XLEN = 32;
    localparam int EXP_MSB = FP_XLEN - 2;
    localparam int EXP_LSB = FP_XLEN - 9;
    localparam int EXP_W   = EXP_MSB - EXP_LSB + 1;
    localparam int MAN_W   = EXP_LSB;

    localparam logic [EXP_W-1:0]   EXP_ALL_ONES = '1;
    localparam logic [FP_XLEN-1:0] QNAN         = 32'h7FC0_0000;

endpackage

// File: rtl/fp_add_arbiter_floating_addition.sv
// ---------------------------------------------------------------------------
// FloatingAddition
// Combinational IEEE-754 single-precision adder shared by both requesters.
// Round-to-nearest-even, denormal inputs/outputs flushed to zero, exact
// cancellation gives +0, overflow gives a signed infinity, NaN inputs or
// Inf - Inf give a quiet NaN.
// Ports:
//   A, B   : input operands
//   result : A + B
// ---------------------------------------------------------------------------
module FloatingAddition
    import fp_add_arbiter_pkg::*;
(
    input  logic [FP_XLEN-1:0] A,
    input  logic [FP_XLEN-1:0] B,
    output logic [FP_XLEN-1:0] result
);

    // hidden bit + stored mantissa + guard, round, sticky
    localparam int FRAC_W = MAN_W + 4;

    logic [EXP_W-1:0]   expA, expB;
    logic [MAN_W-1:0]   manA, manB;
    logic               nanA, nanB, infA, infB;
    logic               bigSign, smallSign;
    logic [EXP_W-1:0]   bigExp, smallExp, expDiff;
    logic [MAN_W-1:0]   bigMan, smallMan;
    logic [FRAC_W-1:0]  bigFrac, smallFrac, alignedFrac, stickyMask;
    logic [FRAC_W:0]    sumFrac;
    logic [FRAC_W-1:0]  normFrac;
    logic [4:0]         leadPos, shiftAmt;
    logic signed [EXP_W+1:0] resExp;
    logic               roundUp;
    logic [MAN_W+1:0]   roundInc;
    logic [MAN_W-1:0]   roundedMan;

    assign expA = A[EXP_MSB:EXP_LSB];
    assign expB = B[EXP_MSB:EXP_LSB];
    assign manA = A[MAN_W-1:0];
    assign manB = B[MAN_W-1:0];
    assign infA = (expA == EXP_ALL_ONES);
    assign infB = (expB == EXP_ALL_ONES);
    assign nanA = infA && (manA != '0);
    assign nanB = infB && (manB != '0);

    // Single combinational datapath: swap by magnitude, align the smaller
    // operand (folding shifted-out bits into sticky), add or subtract,
    // normalise, then round to nearest even.
    always_comb begin
        result      = '0;
        bigSign     = A[FP_XLEN-1];
        smallSign   = B[FP_XLEN-1];
        bigExp      = expA;
        smallExp    = expB;
        bigMan      = manA;
        smallMan    = manB;
        expDiff     = '0;
        bigFrac     = '0;
        smallFrac   = '0;
        alignedFrac = '0;
        stickyMask  = '0;
        sumFrac     = '0;
        normFrac    = '0;
        leadPos     = '0;
        shiftAmt    = '0;
        resExp      = '0;
        roundUp     = 1'b0;
        roundInc    = '0;
        roundedMan  = '0;

        if (B[FP_XLEN-2:0] > A[FP_XLEN-2:0]) begin
            bigSign   = B[FP_XLEN-1];
            smallSign = A[FP_XLEN-1];
            bigExp    = expB;
            smallExp  = expA;
            bigMan    = manB;
            smallMan  = manA;
        end

        if (nanA || nanB || (infA && infB && (A[FP_XLEN-1] != B[FP_XLEN-1]))) begin
            result = QNAN;
        end else if (infA) begin
            result = A;
        end else if (infB) begin
            result = B;
        end else if (expA == '0 && expB == '0) begin
            result = {A[FP_XLEN-1] & B[FP_XLEN-1], {(FP_XLEN-1){1'b0}}};
        end else if (expA == '0) begin
            result = B;
        end else if (expB == '0) begin
            result = A;
        end else begin
            expDiff   = bigExp - smallExp;
            bigFrac   = {1'b1, bigMan, 3'b000};
            smallFrac = {1'b1, smallMan, 3'b000};

            if (expDiff >= EXP_W'(FRAC_W)) begin
                alignedFrac = FRAC_W'(1);
            end else begin
                stickyMask     = (FRAC_W'(1) << expDiff) - FRAC_W'(1);
                alignedFrac    = smallFrac >> expDiff;
                alignedFrac[0] = alignedFrac[0] | (|(smallFrac & stickyMask));
            end

            if (bigSign == smallSign) begin
                sumFrac = {1'b0, bigFrac} + {1'b0, alignedFrac};
            end else begin
                sumFrac = {1'b0, bigFrac} - {1'b0, alignedFrac};
            end

            resExp = signed'({2'b00, bigExp});

            if (sumFrac[FRAC_W]) begin
                normFrac    = sumFrac[FRAC_W:1];
                normFrac[0] = sumFrac[1] | sumFrac[0];
                resExp      = resExp + (EXP_W+2)'(1);
            end else begin
                // Last hit wins, so leadPos ends on the highest set bit.
                for (int i = 0; i < FRAC_W; i++) begin
                    if (sumFrac[i]) begin
                        leadPos = 5'(i);
                    end
                end
                shiftAmt = 5'(FRAC_W - 1) - leadPos;
                normFrac = sumFrac[FRAC_W-1:0] << shiftAmt;
                resExp   = resExp - signed'({{(EXP_W-3){1'b0}}, shiftAmt});
            end

            roundUp  = normFrac[2] & (normFrac[1] | normFrac[0] | normFrac[3]);
            roundInc = {1'b0, normFrac[FRAC_W-1:3]} + (MAN_W+2)'(roundUp);
            if (roundInc[MAN_W+1]) begin
                roundedMan = roundInc[MAN_W:1];
                resExp     = resExp + (EXP_W+2)'(1);
            end else begin
                roundedMan = roundInc[MAN_W-1:0];
            end

            if (sumFrac == '0) begin
                result = '0;
            end else if (resExp >= signed'((EXP_W+2)'(255))) begin
                result = {bigSign, EXP_ALL_ONES, {MAN_W{1'b0}}};
            end else if (resExp <= signed'((EXP_W+2)'(0))) begin
                result = {bigSign, {(FP_XLEN-1){1'b0}}};
            end else begin
                result = {bigSign, resExp[EXP_W-1:0], roundedMan};
            end
        end
    end

endmodule

// File: rtl/fp_add_arbiter.sv
// ---------------------------------------------------------------------------
// fp_add_arbiter
// Two requesters share one combinational FP adder. A round-robin arbiter
// accepts one request in IDLE, the adder result is captured in EXEC, and
// the response is held in RESP until the consumer takes it.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   req0_valid/ready, _a, _b    : requester 0 handshake and operands
//   req1_valid/ready, _a, _b    : requester 1 handshake and operands
//   resp_valid/ready            : response handshake
//   resp_id, resp_result        : granted requester and its sum
//   resp_special                : result exponent all ones (Inf/NaN)
//   busy                        : FSM not in IDLE
//   op_count                    : completed responses, wraps at 16 bits
// ---------------------------------------------------------------------------
module fp_add_arbiter
    import fp_add_arbiter_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [XLEN-1:0]       req0_a,
    input  logic [XLEN-1:0]       req0_b,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [XLEN-1:0]       req1_a,
    input  logic [XLEN-1:0]       req1_b,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  resp_id,
    output logic [XLEN-1:0]       resp_result,
    output logic                  resp_special,
    output logic                  busy,
    output logic [OP_COUNT_W-1:0] op_count
);

    state_t                state_q, state_d;
    logic                  lastGrant_q, lastGrant_d;
    logic [XLEN-1:0]       opA_q, opA_d;
    logic [XLEN-1:0]       opB_q, opB_d;
    logic                  respId_q, respId_d;
    logic [XLEN-1:0]       respResult_q, respResult_d;
    logic                  respSpecial_q, respSpecial_d;
    logic [OP_COUNT_W-1:0] opCount_q, opCount_d;

    logic                  grantId;
    logic                  handshake;
    logic                  respDone;
    logic [XLEN-1:0]       adderSum;

    FloatingAddition uAdder (
        .A      (opA_q),
        .B      (opB_q),
        .result (adderSum)
    );

    // Round-robin: a lone valid wins; on a tie the requester that was not
    // served last wins. Reset leaves lastGrant at 1 so requester 0 wins first.
    always_comb begin
        grantId = 1'b0;
        if (req0_valid && req1_valid) begin
            grantId = ~lastGrant_q;
        end else if (req1_valid) begin
            grantId = 1'b1;
        end
    end

    assign handshake = (req0_ready && req0_valid) || (req1_ready && req1_valid);
    assign respDone  = resp_valid && resp_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one accepted request walks IDLE -> EXEC -> RESP and
    // returns to IDLE only when the response is taken.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (handshake)  state_d = ST_EXEC;
            ST_EXEC:                 state_d = ST_RESP;
            ST_RESP: if (resp_ready) state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    // Output logic. Everything is forced low while rst is high so nothing
    // handshakes during the reset cycles themselves.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        resp_valid = 1'b0;
        busy       = 1'b0;
        if (!rst) begin
            unique case (state_q)
                ST_IDLE: begin
                    req0_ready = req0_valid && !grantId;
                    req1_ready = req1_valid &&  grantId;
                end
                ST_EXEC: begin
                    busy = 1'b1;
                end
                ST_RESP: begin
                    busy       = 1'b1;
                    resp_valid = 1'b1;
                end
                default: begin
                    busy = 1'b0;
                end
            endcase
        end
    end

    // Datapath next-state: operands and id captured on the handshake, the
    // adder output captured in EXEC and then held through RESP.
    always_comb begin
        lastGrant_d   = lastGrant_q;
        opA_d         = opA_q;
        opB_d         = opB_q;
        respId_d      = respId_q;
        respResult_d  = respResult_q;
        respSpecial_d = respSpecial_q;
        opCount_d     = opCount_q;

        if (handshake) begin
            lastGrant_d = grantId;
            respId_d    = grantId;
            opA_d       = grantId ? req1_a : req0_a;
            opB_d       = grantId ? req1_b : req0_b;
        end

        if (state_q == ST_EXEC) begin
            respResult_d  = adderSum;
            respSpecial_d = (adderSum[EXP_MSB:EXP_LSB] == EXP_ALL_ONES);
        end

        if (respDone) begin
            opCount_d = opCount_q + OP_COUNT_W'(1);
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            lastGrant_q   <= 1'b1;
            opA_q         <= '0;
            opB_q         <= '0;
            respId_q      <= 1'b0;
            respResult_q  <= '0;
            respSpecial_q <= 1'b0;
            opCount_q     <= '0;
        end else begin
            lastGrant_q   <= lastGrant_d;
            opA_q         <= opA_d;
            opB_q         <= opB_d;
            respId_q      <= respId_d;
            respResult_q  <= respResult_d;
            respSpecial_q <= respSpecial_d;
            opCount_q     <= opCount_d;
        end
    end

    assign resp_id      = respId_q;
    assign resp_result  = respResult_q;
    assign resp_special = respSpecial_q;
    assign op_count     = opCount_q;

endmodule
